// File: rtl/wb_bus_arbiter.sv
// Round-robin arbiter for the shared 16-bit 4:1 write-back/operand bus.
// Registered one-hot grant and mux select, with burst-bounded pre-emption under contention.
module wb_bus_arbiter #(
    parameter int unsigned MAX_BURST = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] req,
    output logic [3:0] gnt,
    output logic [1:0] sel,
    output logic       bus_valid,
    output logic       gnt_new
);

    localparam int unsigned   CW      = $clog2(MAX_BURST + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_BURST);

    typedef enum logic {
        IDLE,
        BUSY
    } state_e;

    state_e        state_q, state_d;
    logic [1:0]    last_q, last_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    gnt_q, gnt_d;
    logic [1:0]    sel_q, sel_d;
    logic          bus_valid_q, bus_valid_d;
    logic          gnt_new_q, gnt_new_d;

    logic [1:0]    pick;
    logic          pick_found;
    logic [3:0]    owner_oh;
    logic          owner_req;
    logic          others_req;
    logic          grant_pick;
    logic          hold;

    // Search starts one past the last owner, so the owner is only chosen when nobody else asks.
    always_comb begin
        pick       = last_q;
        pick_found = 1'b0;
        for (int unsigned i = 1; i <= 4; i++) begin
            if (!pick_found && req[last_q + 2'(i)]) begin
                pick       = last_q + 2'(i);
                pick_found = 1'b1;
            end
        end
    end

    assign owner_oh   = 4'b0001 << last_q;
    assign owner_req  = req[last_q];
    assign others_req = |(req & ~owner_oh);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            last_q      <= 2'd3;
            cnt_q       <= '0;
            gnt_q       <= '0;
            sel_q       <= '0;
            bus_valid_q <= 1'b0;
            gnt_new_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            cnt_q       <= cnt_d;
            gnt_q       <= gnt_d;
            sel_q       <= sel_d;
            bus_valid_q <= bus_valid_d;
            gnt_new_q   <= gnt_new_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        grant_pick = 1'b0;
        hold       = 1'b0;
        case (state_q)
            IDLE: begin
                if (|req) begin
                    state_d    = BUSY;
                    grant_pick = 1'b1;
                end
            end
            BUSY: begin
                if (owner_req && (!others_req || cnt_q < CNT_MAX)) begin
                    hold = 1'b1;
                end else if (others_req) begin
                    grant_pick = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        gnt_d       = '0;
        sel_d       = sel_q;
        last_d      = last_q;
        cnt_d       = '0;
        bus_valid_d = 1'b0;
        gnt_new_d   = 1'b0;
        if (grant_pick) begin
            gnt_d       = 4'b0001 << pick;
            sel_d       = pick;
            last_d      = pick;
            cnt_d       = CW'(1);
            bus_valid_d = 1'b1;
            gnt_new_d   = 1'b1;
        end else if (hold) begin
            gnt_d       = gnt_q;
            cnt_d       = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);
            bus_valid_d = 1'b1;
        end
    end

    assign gnt       = gnt_q;
    assign sel       = sel_q;
    assign bus_valid = bus_valid_q;
    assign gnt_new   = gnt_new_q;

endmodule

// File: tb/tb_wb_bus_arbiter.sv
// Directed and randomized checks of wb_bus_arbiter against an integer-level ownership model.
module tb_wb_bus_arbiter;

    localparam int MAXB = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] req = 4'b0000;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       bus_valid;
    logic       gnt_new;

    int compared = 0;
    int mismatched = 0;

    // Reference model: who owns the bus and for how many cycles it has held it.
    bit m_busy;
    int m_owner;
    int m_last;
    int m_held;
    int m_sel;
    bit m_new;

    wb_bus_arbiter #(.MAX_BURST(MAXB)) dut (
        .clk      (clk),
        .reset    (reset),
        .req      (req),
        .gnt      (gnt),
        .sel      (sel),
        .bus_valid(bus_valid),
        .gnt_new  (gnt_new)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_busy  = 0;
        m_owner = 0;
        m_last  = 3;
        m_held  = 0;
        m_sel   = 0;
        m_new   = 0;
    endfunction

    function automatic void model_edge(input logic [3:0] r);
        int  p;
        bit  others;
        p = -1;
        for (int k = 1; k <= 4; k++) begin
            if (p < 0 && r[(m_last + k) % 4]) p = (m_last + k) % 4;
        end
        others = 0;
        for (int j = 0; j < 4; j++) if (r[j] && !(m_busy && j == m_owner)) others = 1;
        m_new = 0;
        if (m_busy && r[m_owner] && (!others || m_held < MAXB)) begin
            if (m_held < MAXB) m_held++;
        end else if (p >= 0) begin
            m_busy  = 1;
            m_owner = p;
            m_last  = p;
            m_sel   = p;
            m_held  = 1;
            m_new   = 1;
        end else begin
            m_busy = 0;
            m_held = 0;
        end
    endfunction

    task automatic compare_model();
        logic [3:0] eg;
        eg = m_busy ? (4'b0001 << m_owner) : 4'b0000;
        chk("gnt", 8'(gnt), 8'(eg));
        chk("sel", 8'(sel), 8'(m_sel));
        chk("bus_valid", 8'(bus_valid), 8'(m_busy));
        chk("gnt_new", 8'(gnt_new), 8'(m_new));
    endtask

    // Apply req (and current reset), clock one edge, update model, sample 1 time unit later.
    task automatic step(input logic [3:0] r);
        req = r;
        @(posedge clk);
        if (reset) model_reset();
        else model_edge(r);
        #1;
        compare_model();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step(4'b0000);
        reset = 1'b0;
    endtask

    initial begin
        logic [3:0] r;
        model_reset();
        #1;
        do_reset();
        chk("reset_gnt", 8'(gnt), 8'h00);
        chk("reset_sel", 8'(sel), 8'h00);

        // Idle bus
        for (int i = 0; i < 5; i++) step(4'b0000);
        chk("idle_valid", 8'(bus_valid), 8'h00);

        // Single requester, no pre-emption
        for (int i = 0; i < 10; i++) begin
            step(4'b0100);
            chk("single_gnt", 8'(gnt), 8'h04);
            chk("single_new", 8'(gnt_new), (i == 0) ? 8'h01 : 8'h00);
        end
        step(4'b0000);
        chk("single_rel_gnt", 8'(gnt), 8'h00);
        chk("single_rel_sel", 8'(sel), 8'h02);

        // Full contention from reset: 0,1,2,3,0 each for MAXB cycles
        do_reset();
        for (int i = 0; i < 5 * MAXB; i++) begin
            step(4'b1111);
            r = 4'b0001 << ((i / MAXB) % 4);
            chk("rr_gnt", 8'(gnt), 8'(r));
            chk("rr_new", 8'(gnt_new), (i % MAXB == 0) ? 8'h01 : 8'h00);
        end

        // Early release with handoff, requester 0 dropped
        do_reset();
        step(4'b0010);
        step(4'b0011);
        chk("early_owner", 8'(gnt), 8'h02);
        step(4'b1000);
        chk("early_gnt", 8'(gnt), 8'h08);
        chk("early_sel", 8'(sel), 8'h03);
        chk("early_new", 8'(gnt_new), 8'h01);

        // Re-grant after one idle cycle
        step(4'b0100);
        step(4'b0100);
        step(4'b0000);
        step(4'b0100);
        chk("regrant_gnt", 8'(gnt), 8'h04);
        chk("regrant_new", 8'(gnt_new), 8'h01);
        step(4'b0000);
        step(4'b0101);
        chk("wrap_gnt", 8'(gnt), 8'h01);
        chk("wrap_sel", 8'(sel), 8'h00);

        // Reset mid-burst while requester 1 owns the bus
        do_reset();
        for (int i = 0; i < MAXB + 1; i++) step(4'b1111);
        chk("pre_reset_gnt", 8'(gnt), 8'h02);
        reset = 1'b1;
        step(4'b1111);
        reset = 1'b0;
        chk("midreset_gnt", 8'(gnt), 8'h00);
        chk("midreset_valid", 8'(bus_valid), 8'h00);
        chk("midreset_new", 8'(gnt_new), 8'h00);
        step(4'b1111);
        chk("post_reset_gnt", 8'(gnt), 8'h01);

        // Randomized traffic with occasional resets
        r = 4'b0000;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 3) == 0) r = 4'($urandom_range(0, 15));
            reset = ($urandom_range(0, 79) == 0);
            step(r);
        end
        reset = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/wb_bus_arbiter.md
# wb_bus_arbiter

Round-robin arbiter that shares the 16-bit 4:1 write-back/operand bus between four requesters. It drives the 2-bit select of the 4:1 16-bit bus multiplexer (`mux4_to_1`) and a one-hot grant back to each requester. Grants are registered and held while the owner keeps requesting. Ownership is pre-empted after a bounded burst when another requester is waiting.

## Interface
- `MAX_BURST`, default 4: maximum consecutive grant cycles an owner keeps the bus while any other requester is pending. Legal range 1..15.
- `clk`  input  1  single system clock; all state updates on its rising edge.
- `reset`  input  1  synchronous, active-high reset, sampled on the rising edge of `clk`.
- `req`  input  4  request per requester; bit i high means requester i wants the bus this cycle.
- `gnt`  output  4  registered one-hot grant; all-zero when the bus is idle.
- `sel`  output  2  registered mux select, equal to the index of the granted requester. Holds the last owner's index while idle.
- `bus_valid`  output  1  registered; high exactly when `gnt` is non-zero.
- `gnt_new`  output  1  registered one-cycle pulse on the first cycle of each new grant, including a re-grant of the same index after an idle cycle.

## Operation
- State machine with two states:
  - IDLE: `gnt` = 0.
  - BUSY: `gnt` = one-hot of the current owner.
- Internal state:
  - `last`, 2 bits: index of the most recent owner. Reset value 3, so requester 0 has top priority after reset.
  - `cnt`: burst counter, `$clog2(MAX_BURST+1)` bits, saturating at `MAX_BURST`.
- Round-robin pick: search indices `last+1`, `last+2`, `last+3`, `last` (mod 4) and take the first with `req` set. Wrap 3→0 is required.
- IDLE → BUSY: when any `req` bit is high.
  - Grant the pick.
  - `sel` and `last` take the pick; `cnt` = 1; `gnt_new` = 1.
- BUSY, owner request still high, no other request: keep the grant. `cnt` increments, saturating at `MAX_BURST`.
- BUSY, owner request still high, another request pending:
  - If `cnt` < `MAX_BURST`: keep the grant and increment `cnt`.
  - If `cnt` == `MAX_BURST`: hand over at this edge to the round-robin pick, which excludes the owner because it starts at `last+1`. `cnt` = 1, `gnt_new` = 1.
- BUSY, owner request low:
  - Others pending: hand over to the pick at the same edge with no idle cycle. `cnt` = 1, `gnt_new` = 1.
  - No requests: go to IDLE. `gnt` = 0, `bus_valid` = 0; `sel` and `last` unchanged; `cnt` = 0.
- `gnt` is always one-hot or zero. `sel` always matches the set bit of `gnt` when `bus_valid` = 1.
- `req` bits are not latched. A request that drops before it is granted is simply lost.

## Timing
- Reset values: `gnt` = 0, `sel` = 2'b00, `bus_valid` = 0, `gnt_new` = 0, state IDLE, `last` = 3, `cnt` = 0.
- Reset asserted mid-burst: all outputs return to reset values on that edge, regardless of `req`.
- Grant latency: a `req` sampled high at edge N, with the bus free, produces `gnt`/`sel`/`bus_valid` valid after edge N, i.e. during cycle N+1.
- Release latency: owner `req` sampled low at edge N means `gnt` is dropped or moved after edge N.
- The owner holds the bus for its final cycle of `req` plus no extra cycle.
- Downstream datapath: the mux output for owner i is valid in every cycle where `gnt[i]` = 1.
- Burst bound: while contended, an owner holds at most `MAX_BURST` consecutive cycles. Worst-case wait for any requester holding `req` high is 3×`MAX_BURST` cycles.
- Outputs are all registered; there is no combinational path from `req` to any output.

## Test plan
- Reset, then `req` = 4'b0000 for 5 cycles: `gnt` = 0, `sel` = 0, `bus_valid` = 0, `gnt_new` = 0 throughout.
- Single requester: `req` = 4'b0100 held for 10 cycles, then 0.
  - One cycle later: `gnt` = 4'b0100, `sel` = 2, `gnt_new` pulses once.
  - Grant held for 10 cycles with no pre-emption.
  - Then `gnt` = 0 and `sel` stays 2.
- Full contention, `MAX_BURST` = 4: `req` = 4'b1111 held continuously from reset.
  - Grant order is 0,1,2,3,0, each for exactly 4 cycles.
  - `gnt_new` pulses every 4 cycles; `sel` walks 0→1→2→3→0, including the 3→0 wrap.
- Early release with handoff: requester 1 owns the bus, and `req` changes from 4'b0011 to 4'b1000 (requester 3 newly raised) before the burst limit.
  - Next cycle: `gnt` = 4'b1000, `sel` = 3, no idle cycle.
  - Requester 0 is not granted because its request dropped.
- Re-grant after idle: requester 2 releases, bus idles 1 cycle, then `req` = 4'b0100 again.
  - `gnt` = 4'b0100 with `gnt_new` = 1.
  - With `req` = 4'b0101 instead, requester 0 wins, because the search starts at `last+1` = 3 and wraps to 0.
- Reset mid-burst: `reset` asserted for 1 cycle while `gnt` = 4'b0010 and `req` = 4'b1111.
  - All outputs return to reset values on that edge.
  - After release, the first grant is requester 0.
